// File: rtl/ibex_pkg.sv
// Shared definitions for the message register file: loader FSM states and
// the width of a burst-length field for a given maximum burst.
package ibex_pkg;

  localparam int MaxBurstLimit = 8;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  // Bits needed to encode a burst length from 0 up to max_burst inclusive.
  function automatic int ld_len_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ibex_msg_burst_loader.sv
// Burst-load sequencer: accepts a base/length command, then steps through
// message-bank addresses as data words are handed over.
module ibex_msg_burst_loader
  import ibex_pkg::*;
#(
  parameter int NumWords  = 32,
  parameter int MaxBurst  = 4,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int LenWidth  = ld_len_width(MaxBurst)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_start_i,
  input  logic [AddrWidth-1:0] ld_base_i,
  input  logic [LenWidth-1:0]  ld_len_i,
  input  logic                 ld_valid_i,
  input  logic                 core_msg_we_i,
  output logic                 ld_ready_o,
  output logic                 ld_busy_o,
  output logic                 ld_done_o,
  output logic                 err_o,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] wr_addr_o
);

  ld_state_e            state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready;
  logic                 len_ok;

  assign len_ok = (ld_len_i != '0) && (ld_len_i <= LenWidth'(MaxBurst));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready   = 1'b0;
    wr_en_o = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          if (len_ok) begin
            state_d = LD_LOAD;
            base_d  = ld_base_i;
            len_d   = ld_len_i;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        // Data offered with no load in progress is a protocol error.
        if (ld_valid_i) err_d = 1'b1;
      end
      LD_LOAD: begin
        // A core write to the message bank owns the write port this cycle.
        ready = !core_msg_we_i;
        if (ld_valid_i && ready) begin
          wr_en_o = 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = LD_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign wr_addr_o  = base_q + AddrWidth'(cnt_q);
  assign ld_ready_o = ready;
  assign ld_busy_o  = (state_q == LD_LOAD);
  assign ld_done_o  = done_q;
  assign err_o      = err_q;

endmodule

// File: rtl/ibex_msg_register_file.sv
// Register file with a GPR bank (word 0 hard-wired) and a fully writable
// message bank that can be filled by the core or by a burst loader.
module ibex_msg_register_file
  import ibex_pkg::*;
#(
  parameter int                 DataWidth   = 32,
  parameter int                 NumWords    = 32,
  parameter int                 MaxBurst    = 4,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int LenWidth  = ld_len_width(MaxBurst)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [AddrWidth-1:0]               raddr_a_i,
  output logic [DataWidth-1:0]               rdata_a_o,
  input  logic [AddrWidth-1:0]               raddr_b_i,
  output logic [DataWidth-1:0]               rdata_b_o,
  input  logic                               we_i,
  input  logic [AddrWidth-1:0]               waddr_i,
  input  logic [DataWidth-1:0]               wdata_i,
  input  logic                               msg_sel_i,
  input  logic [AddrWidth-1:0]               raddr_msg_i,
  output logic [MaxBurst-1:0][DataWidth-1:0] rdata_msg_o,
  input  logic                               ld_start_i,
  input  logic [AddrWidth-1:0]               ld_base_i,
  input  logic [LenWidth-1:0]                ld_len_i,
  input  logic                               ld_valid_i,
  output logic                               ld_ready_o,
  input  logic [DataWidth-1:0]               ld_data_i,
  output logic                               ld_busy_o,
  output logic                               ld_done_o,
  output logic                               err_o
);

  logic [DataWidth-1:0] gpr_q [1:NumWords-1];
  logic [DataWidth-1:0] msg_q [NumWords];
  logic                 core_msg_we;
  logic                 ld_we;
  logic [AddrWidth-1:0] ld_waddr;

  assign core_msg_we = we_i && msg_sel_i;

  ibex_msg_burst_loader #(
    .NumWords (NumWords),
    .MaxBurst (MaxBurst)
  ) u_loader (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ld_start_i    (ld_start_i),
    .ld_base_i     (ld_base_i),
    .ld_len_i      (ld_len_i),
    .ld_valid_i    (ld_valid_i),
    .core_msg_we_i (core_msg_we),
    .ld_ready_o    (ld_ready_o),
    .ld_busy_o     (ld_busy_o),
    .ld_done_o     (ld_done_o),
    .err_o         (err_o),
    .wr_en_o       (ld_we),
    .wr_addr_o     (ld_waddr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumWords; i++) gpr_q[i] <= WordZeroVal;
    end else if (we_i && !msg_sel_i && (waddr_i != '0)) begin
      gpr_q[waddr_i] <= wdata_i;
    end
  end

  // Core and loader never write together: the loader is stalled by ld_ready_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) msg_q[i] <= WordZeroVal;
    end else if (core_msg_we) begin
      msg_q[waddr_i] <= wdata_i;
    end else if (ld_we) begin
      msg_q[ld_waddr] <= ld_data_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? WordZeroVal : gpr_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? WordZeroVal : gpr_q[raddr_b_i];

  always_comb begin
    rdata_msg_o = '0;
    for (int k = 0; k < MaxBurst; k++) begin
      rdata_msg_o[k] = msg_q[raddr_msg_i + AddrWidth'(k)];
    end
  end

endmodule

// File: tb/tb_ibex_msg_register_file.sv
// Directed bench for ibex_msg_register_file with hand-computed expectations.
module tb_ibex_msg_register_file;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       raddr_a, raddr_b, waddr, raddr_msg, ld_base;
  logic [31:0]      rdata_a, rdata_b, wdata, ld_data;
  logic             we, msg_sel, ld_start, ld_valid;
  logic [2:0]       ld_len;
  logic [3:0][31:0] rdata_msg;
  logic             ld_ready, ld_busy, ld_done, err;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen;

  ibex_msg_register_file dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .raddr_a_i   (raddr_a),
    .rdata_a_o   (rdata_a),
    .raddr_b_i   (raddr_b),
    .rdata_b_o   (rdata_b),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .msg_sel_i   (msg_sel),
    .raddr_msg_i (raddr_msg),
    .rdata_msg_o (rdata_msg),
    .ld_start_i  (ld_start),
    .ld_base_i   (ld_base),
    .ld_len_i    (ld_len),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_data_i   (ld_data),
    .ld_busy_o   (ld_busy),
    .ld_done_o   (ld_done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; raddr_a = 5'd5; raddr_b = 5'd5; waddr = '0; wdata = '0;
    we = 1'b0; msg_sel = 1'b0; raddr_msg = 5'd5; ld_start = 1'b0;
    ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    #2;
    check_eq("rst_ready", ld_ready, 0);
    check_eq("rst_busy", ld_busy, 0);
    check_eq("rst_done", ld_done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_gpr5", rdata_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // GPR write, no bypass in the write cycle
    we = 1'b1; msg_sel = 1'b0; waddr = 5'd5; wdata = 32'hDEADBEEF;
    #1 check_eq("gpr_nobypass", rdata_a, 0);
    tick();
    we = 1'b0;
    #1;
    check_eq("gpr_a5", rdata_a, 32'hDEADBEEF);
    check_eq("gpr_b5", rdata_b, 32'hDEADBEEF);
    check_eq("msg5_untouched", rdata_msg[0], 0);

    // Word 0 in both banks
    we = 1'b1; msg_sel = 1'b0; waddr = 5'd0; wdata = 32'h1234;
    tick();
    msg_sel = 1'b1;
    tick();
    we = 1'b0; msg_sel = 1'b0; raddr_a = 5'd0; raddr_msg = 5'd0;
    #1;
    check_eq("gpr0_zero", rdata_a, 0);
    check_eq("msg0_written", rdata_msg[0], 32'h1234);

    // Illegal lengths
    ld_start = 1'b1; ld_len = 3'd0; ld_base = 5'd3;
    tick();
    ld_start = 1'b0;
    #1;
    check_eq("len0_err", err, 1);
    check_eq("len0_idle", ld_busy, 0);
    tick();
    check_eq("len0_err_clr", err, 0);
    ld_start = 1'b1; ld_len = 3'd5;
    tick();
    ld_start = 1'b0;
    #1;
    check_eq("len5_err", err, 1);
    check_eq("len5_idle", ld_busy, 0);
    tick();

    // Data offered while idle
    ld_valid = 1'b1; ld_data = 32'h55;
    #1 check_eq("idle_ready", ld_ready, 0);
    tick();
    ld_valid = 1'b0;
    #1;
    check_eq("idle_valid_err", err, 1);
    tick();
    check_eq("idle_valid_err_clr", err, 0);

    // Wrapped burst load 30,31,0,1
    ld_start = 1'b1; ld_base = 5'd30; ld_len = 3'd4;
    tick();
    ld_start = 1'b0;
    #1;
    check_eq("load_busy", ld_busy, 1);
    check_eq("load_ready", ld_ready, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + i;
      ld_start = (i == 1); ld_len = 3'd0;
      tick();
      if (i < 3) check_eq("load_no_early_done", ld_done, 0);
      if (i == 1) check_eq("start_in_load_no_err", err, 0);
    end
    ld_valid = 1'b0; ld_start = 1'b0; raddr_msg = 5'd30;
    #1;
    check_eq("load_done", ld_done, 1);
    check_eq("load_idle", ld_busy, 0);
    check_eq("burst_k0", rdata_msg[0], 32'hA0);
    check_eq("burst_k1", rdata_msg[1], 32'hA1);
    check_eq("burst_k2", rdata_msg[2], 32'hA2);
    check_eq("burst_k3", rdata_msg[3], 32'hA3);
    tick();
    check_eq("done_one_cycle", ld_done, 0);

    // Stall: core message write collides with loader data
    ld_start = 1'b1; ld_base = 5'd10; ld_len = 3'd2;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hB0;
    we = 1'b1; msg_sel = 1'b1; waddr = 5'd7; wdata = 32'h77;
    #1 check_eq("stall_ready", ld_ready, 0);
    tick();
    we = 1'b0; msg_sel = 1'b0; raddr_msg = 5'd7;
    #1;
    check_eq("stall_ready_back", ld_ready, 1);
    check_eq("stall_core_data", rdata_msg[0], 32'h77);
    check_eq("stall_not_loaded", rdata_msg[3], 0);
    tick();
    ld_data = 32'hB1;
    tick();
    ld_valid = 1'b0; raddr_msg = 5'd10;
    #1;
    check_eq("stall_done", ld_done, 1);
    check_eq("stall_w0", rdata_msg[0], 32'hB0);
    check_eq("stall_w1", rdata_msg[1], 32'hB1);
    tick();

    // Reset in the middle of a load
    ld_start = 1'b1; ld_base = 5'd20; ld_len = 3'd4;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hC0 + i;
      tick();
    end
    ld_valid = 1'b0; raddr_msg = 5'd20;
    #1;
    check_eq("mid_w0", rdata_msg[0], 32'hC0);
    check_eq("mid_busy", ld_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", ld_busy, 0);
    check_eq("abort_w0", rdata_msg[0], 0);
    check_eq("abort_w1", rdata_msg[1], 0);
    raddr_a = 5'd5; raddr_msg = 5'd0;
    #1;
    check_eq("abort_gpr5", rdata_a, 0);
    check_eq("abort_msg0", rdata_msg[0], 0);
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ld_done) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    check_eq("abort_idle", ld_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
